multicycle_alu: RTL

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
// Handshaked ALU: single-cycle logic/arith ops, WIDTH-cycle iterative shift-add multiply.
// Results and status flags are held until the consumer takes them.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [3:0]       command,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carryout,
    output logic             overflow,
    output logic             error
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MULT = 4'd11;
    localparam logic [3:0] OP_SLTU = 4'd12;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;
    logic             r_ovf;
    logic             r_err;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_count;

    logic             w_accept;
    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_carry;
    logic             w_alu_ovf;
    logic             w_alu_err;
    logic [WIDTH-1:0] w_acc_next;

    assign w_accept   = in_valid && (r_state == IDLE);
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // SUB shares the adder: A + ~B + 1, so carry out means "no borrow".
    always_comb begin
        w_sub        = (command == OP_SUB);
        w_b_eff      = w_sub ? ~operandB : operandB;
        w_sum        = {1'b0, operandA} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
        w_shamt      = operandB[SHW-1:0];
        w_alu_result = '0;
        w_alu_carry  = 1'b0;
        w_alu_ovf    = 1'b0;
        w_alu_err    = 1'b0;
        case (command)
            OP_ADD, OP_SUB: begin
                w_alu_result = w_sum[WIDTH-1:0];
                w_alu_carry  = w_sum[WIDTH];
                w_alu_ovf    = (operandA[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                               (w_sum[WIDTH-1] != operandA[WIDTH-1]);
            end
            OP_XOR:  w_alu_result = operandA ^ operandB;
            OP_SLT:  w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
            OP_AND:  w_alu_result = operandA & operandB;
            OP_NAND: w_alu_result = ~(operandA & operandB);
            OP_NOR:  w_alu_result = ~(operandA | operandB);
            OP_OR:   w_alu_result = operandA | operandB;
            OP_SLL:  w_alu_result = operandA << w_shamt;
            OP_SRL:  w_alu_result = operandA >> w_shamt;
            OP_SRA:  w_alu_result = $unsigned($signed(operandA) >>> w_shamt);
            OP_MULT: w_alu_result = '0;
            OP_SLTU: w_alu_result = {{(WIDTH-1){1'b0}}, (operandA < operandB)};
            default: w_alu_err    = 1'b1;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = (r_state == IDLE);
        out_valid    = (r_state == HOLD);
        case (r_state)
            IDLE: if (in_valid) w_state_next = (command == OP_MULT) ? BUSY : HOLD;
            BUSY: if (r_count == CNT_LAST) w_state_next = HOLD;
            HOLD: if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (w_accept) begin
            if (command == OP_MULT) begin
                r_mcand  <= operandA;
                r_mplier <= operandB;
                r_acc    <= '0;
                r_count  <= '0;
            end else begin
                r_result <= w_alu_result;
                r_zero   <= (w_alu_result == '0);
                r_carry  <= w_alu_carry;
                r_ovf    <= w_alu_ovf;
                r_err    <= w_alu_err;
            end
        end else if (r_state == BUSY) begin
            // One multiplier bit per cycle; the last step writes straight into the result.
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + SHW'(1);
            if (r_count == CNT_LAST) begin
                r_result <= w_acc_next;
                r_zero   <= (w_acc_next == '0);
                r_carry  <= 1'b0;
                r_ovf    <= 1'b0;
                r_err    <= 1'b0;
            end
        end
    end

    assign result   = r_result;
    assign zero     = r_zero;
    assign carryout = r_carry;
    assign overflow = r_ovf;
    assign error    = r_err;

endmodule
